waveform_buffer_ctrl: RTL
=========================

Name: waveform_buffer_ctrl

Overview:
Sample-history controller for the scope display. Captures raw (8-bit) and matched-filter (16-bit) samples into a single-port circular sample RAM and arbitrates that RAM between sample writes and per-column display reads. Display reads drive the red and blue waveform renderers' signal inputs. Display reads own the RAM during the active area; writes are queued in an internal FIFO and drained in blanking. Sits between the sample/filter pipeline and main_display.

Parameters:
ADDR_W, 10, log2 of sample RAM depth (1024 words).
FIFO_AW, 3, log2 of write FIFO depth (8 entries).
H_ACTIVE, 1024, active columns; hcount below this is a display column.
V_ACTIVE, 768, active rows.
RAW_MID, 8'h80, raw value written during clear.

Ports:
clk  in  1  pixel clock, 65 MHz.
reset  in  1  asynchronous, active-high.
sample_valid  in  1  one-cycle strobe: new sample pair present.
sample_raw  in  8  raw ADC sample.
sample_mf  in  16  matched-filter sample.
freeze  in  1  hold displayed trace; incoming samples discarded.
hcount  in  11  current column.
vcount  in  10  current row.
ram_addr  out  ADDR_W  sample RAM address.
ram_we  out  1  sample RAM write enable.
ram_wdata  out  24  {raw, mf} write word.
ram_rdata  in  24  read word; valid 1 cycle after address.
signal_raw_out  out  8  raw sample for column pix_col.
signal_mf_out  out  16  MF sample for column pix_col.
pix_col  out  11  column tag of the signal outputs.
pix_valid  out  1  signal outputs valid.
clear_busy  out  1  RAM clear in progress.
overflow  out  1  sticky: sample dropped on full FIFO.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: all outputs 0, wr_ptr 0, base_ptr 0, FIFO empty, state S_CLEAR.
- FSM states:
  - S_CLEAR: write {RAW_MID,16'h0000} to addresses 0 to 2^ADDR_W-1, one per cycle; clear_busy=1; no display reads.
  - S_CLEAR exits to S_BLANK after the last address. It takes exactly 2^ADDR_W cycles.
  - S_DISP: hcount<H_ACTIVE and vcount<V_ACTIVE.
  - S_BLANK: all other cycles.
  - S_DISP and S_BLANK are re-evaluated every cycle from hcount and vcount.
- Display read (S_DISP): ram_addr = (base_ptr + hcount) mod 2^ADDR_W, ram_we=0.
  - 2-cycle latency: registered address plus RAM, then an output register.
  - signal_*_out, pix_col=hcount and pix_valid appear 2 cycles after that hcount.
  - pix_valid=0 for columns not read. The top level delays hcount and vcount by 2 to match.
- Write drain (S_BLANK): if the FIFO is non-empty, pop, write the word at wr_ptr, then wr_ptr++ (wraps).
  - Maximum one write per cycle.
  - Writes never occur in S_DISP.
- FIFO push: on sample_valid with freeze=0 and not full. Pushing is allowed during S_CLEAR.
- Full FIFO:
  - Push and pop in the same cycle on a full FIFO: both occur; no drop.
  - A push on a full FIFO with no pop: sample dropped, overflow set. overflow clears only on reset.
- Frozen input: sample_valid while freeze=1 is discarded silently.
- Base pointer: at hcount==0 && vcount==0 with freeze=0, base_ptr <= wr_ptr - H_ACTIVE (mod). The newest sample lands on the right edge.
  - With freeze=1 the base is held.
  - The base is never changed mid-frame.
- Pointer arithmetic: all pointer arithmetic is ADDR_W-bit unsigned with wrap.
- Reset mid-operation: returns to S_CLEAR, restarts clear at address 0, empties the FIFO, and clears overflow.

Decomposition:
- Shared display package: constants H_ACTIVE, V_ACTIVE, the sample word layout (raw [23:16], mf [15:0]) and the FSM state encoding.
- One sub-module, sample_fifo: synchronous FIFO (width 24, depth 2^FIFO_AW) with full/empty and simultaneous push/pop. Its push-on-full drop signal feeds overflow.

Test Plan:
- Reset release -> clear_busy high exactly 1024 cycles; every RAM word reads 24'h800000; overflow=0.
- Sample raw=8'h5A, mf=16'h1234 at hcount=1100 (blanking), FIFO empty -> RAM word at wr_ptr=0 is 24'h5A1234 on the following cycle; wr_ptr=1.
- 3 samples during an active line -> no ram_we in S_DISP; all 3 written on consecutive cycles starting at hcount=1024.
- 9 samples during one active line -> 8 written in blanking; overflow=1 and sticks until reset.
- Frame start with wr_ptr=10 -> base_ptr=10-1024 mod 1024=10; at hcount=5, read addr=15; 2 cycles later pix_col=5, pix_valid=1, data matches word 15.
- freeze=1 across a frame start plus samples -> base_ptr unchanged, FIFO empty, no writes; reset asserted mid-clear at address 300 -> clear restarts at 0.

Source files
------------

// File: rtl/waveform_buffer_ctrl_pkg.sv
// Shared display constants, sample word layout and controller state encoding
// for the waveform sample-history buffer.
package waveform_buffer_ctrl_pkg;

  localparam int unsigned H_ACTIVE = 1024;
  localparam int unsigned V_ACTIVE = 768;
  localparam int unsigned HC_W     = 11;
  localparam int unsigned VC_W     = 10;
  localparam int unsigned WORD_W   = 24;

  typedef struct packed {
    logic [7:0]  raw;
    logic [15:0] mf;
  } sample_word_t;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_BLANK = 2'd1,
    S_DISP  = 2'd2
  } state_t;

  function automatic logic in_active(input logic [HC_W-1:0] hc, input logic [VC_W-1:0] vc);
    return (hc < HC_W'(H_ACTIVE)) && (vc < VC_W'(V_ACTIVE));
  endfunction

endpackage

// File: rtl/waveform_buffer_ctrl_sample_fifo.sv
// Synchronous sample FIFO with simultaneous push/pop; a push that finds the
// FIFO full with no pop in the same cycle is dropped and flagged.
module sample_fifo
  import waveform_buffer_ctrl_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  sample_word_t wdata,
  input  logic         pop,
  output sample_word_t rdata_c,
  output logic         full_c,
  output logic         empty_c,
  output logic         drop_c
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  sample_word_t  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    full_c  = (count == CW'(DEPTH));
    empty_c = (count == '0);
    do_pop  = pop && !empty_c;
    do_push = push && (!full_c || do_pop);
    drop_c  = push && full_c && !do_pop;
    rdata_c = mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + AW'(1);
      if (do_pop)  rd_idx <= rd_idx + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/waveform_buffer_ctrl.sv
// Sample-history controller: clears the circular sample RAM, queues incoming
// samples, drains them in blanking and serves per-column display reads.
module waveform_buffer_ctrl
  import waveform_buffer_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned FIFO_AW = 3,
  parameter logic [7:0]  RAW_MID = 8'h80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [7:0]        sample_raw,
  input  logic [15:0]       sample_mf,
  input  logic              freeze,
  input  logic [HC_W-1:0]   hcount,
  input  logic [VC_W-1:0]   vcount,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [7:0]        signal_raw_out,
  output logic [15:0]       signal_mf_out,
  output logic [HC_W-1:0]   pix_col,
  output logic              pix_valid,
  output logic              clear_busy,
  output logic              overflow
);

  state_t            st;
  state_t            mode_c;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] base_ptr;
  logic [ADDR_W-1:0] rd_base_c;
  logic              frame_start_c;
  logic              push_c;
  logic              pop_c;
  logic              full_c;
  logic              empty_c;
  logic              drop_c;
  sample_word_t      in_word;
  sample_word_t      head_c;
  sample_word_t      rd_word;
  logic              rd_q;
  logic [HC_W-1:0]   col_q;

  assign in_word = '{raw: sample_raw, mf: sample_mf};
  assign rd_word = ram_rdata;

  sample_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .wdata   (in_word),
    .pop     (pop_c),
    .rdata_c (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .drop_c  (drop_c)
  );

  // Display/blank is decided from the live raster position every cycle; the
  // frame-start base is forwarded so column 0 already uses the new base.
  always_comb begin
    mode_c        = (st == S_CLEAR) ? S_CLEAR : (in_active(hcount, vcount) ? S_DISP : S_BLANK);
    frame_start_c = (hcount == '0) && (vcount == '0) && !freeze;
    rd_base_c     = frame_start_c ? (wr_ptr - ADDR_W'(H_ACTIVE)) : base_ptr;
    push_c        = sample_valid && !freeze;
    pop_c         = (mode_c == S_BLANK) && !empty_c;
    clear_busy    = (st == S_CLEAR) && !reset;
  end

  // RAM port ownership: clear sweep, display read, or FIFO drain.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (mode_c)
      S_CLEAR: begin
        ram_we    = !reset;
        ram_addr  = clr_cnt;
        ram_wdata = reset ? '0 : {RAW_MID, 16'h0000};
      end
      S_DISP: begin
        ram_addr = rd_base_c + ADDR_W'(hcount);
      end
      default: begin
        if (pop_c) begin
          ram_we    = 1'b1;
          ram_addr  = wr_ptr;
          ram_wdata = head_c;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st             <= S_CLEAR;
      clr_cnt        <= '0;
      wr_ptr         <= '0;
      base_ptr       <= '0;
      rd_q           <= 1'b0;
      col_q          <= '0;
      pix_valid      <= 1'b0;
      pix_col        <= '0;
      signal_raw_out <= '0;
      signal_mf_out  <= '0;
      overflow       <= 1'b0;
    end else begin
      if (st == S_CLEAR) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
        if (clr_cnt == '1) st <= S_BLANK;
      end
      if (pop_c)         wr_ptr   <= wr_ptr + ADDR_W'(1);
      if (frame_start_c) base_ptr <= rd_base_c;
      if (drop_c)        overflow <= 1'b1;
      rd_q      <= (mode_c == S_DISP);
      col_q     <= hcount;
      pix_valid <= rd_q;
      pix_col   <= col_q;
      if (rd_q) begin
        signal_raw_out <= rd_word.raw;
        signal_mf_out  <= rd_word.mf;
      end
    end
  end

endmodule
